// File: rtl/shift_add_mul_ctrl_if.sv
// ---------------------------------------------------------------------------
// shift_add_mul_ctrl_if
//
// Bundles the multiply request/result handshake and the external adder hookup
// of shift_add_mul_ctrl.
//
// Signals (N = operand width):
//   start    requester -> ctrl   request a multiply (sampled only when idle)
//   a, b     requester -> ctrl   unsigned multiplicand / multiplier, N bits
//   busy     ctrl -> requester   high while an operation is running or done
//   done     ctrl -> requester   one-cycle pulse, product valid
//   product  ctrl -> requester   2N-bit result
//   add_a    ctrl -> adder       adder operand A, N bits
//   add_b    ctrl -> adder       adder operand B, N bits
//   add_sum  adder -> ctrl       adder result {cout, sum}, N+1 bits
//
// Modports:
//   slave   the multiply controller
//   master  the requester, which also owns the combinational adder
// ---------------------------------------------------------------------------
interface shift_add_mul_ctrl_if #(
    parameter int unsigned N = 32
);
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;
    logic [N-1:0]   add_a;
    logic [N-1:0]   add_b;
    logic [N:0]     add_sum;

    modport slave (
        input  start,
        input  a,
        input  b,
        input  add_sum,
        output busy,
        output done,
        output product,
        output add_a,
        output add_b
    );

    modport master (
        output start,
        output a,
        output b,
        output add_sum,
        input  busy,
        input  done,
        input  product,
        input  add_a,
        input  add_b
    );
endinterface

// File: rtl/shift_add_mul_ctrl.sv
// ---------------------------------------------------------------------------
// shift_add_mul_ctrl
//
// Unsigned N x N -> 2N multiply by N shift-and-add iterations through an
// external N-bit adder. One iteration per clock; start-accept to done is N+1
// cycles, one multiply every N+2 cycles.
//
// Ports:
//   i_clk    clock, all state changes on the rising edge
//   i_rst    synchronous active-high reset, overrides start
//   io_mul   shift_add_mul_ctrl_if.slave:
//              start/a/b in, busy/done/product out,
//              add_a/add_b out to the adder, add_sum in from the adder
//
// The interface instance must be built with the same N as this module.
// ---------------------------------------------------------------------------
module shift_add_mul_ctrl #(
    parameter int unsigned N = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    shift_add_mul_ctrl_if.slave  io_mul
);

    localparam int unsigned   CntW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e          r_state;
    logic [N-1:0]    r_mcand;
    logic [N-1:0]    r_acc_hi;
    logic [N-1:0]    r_acc_lo;
    logic [CntW-1:0] r_cnt;

    state_e          w_state_nxt;
    logic [N-1:0]    w_mcand_nxt;
    logic [N-1:0]    w_acc_hi_nxt;
    logic [N-1:0]    w_acc_lo_nxt;
    logic [CntW-1:0] w_cnt_nxt;
    logic [N-1:0]    w_add_a;
    logic [N-1:0]    w_add_b;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_mcand  <= w_mcand_nxt;
            r_acc_hi <= w_acc_hi_nxt;
            r_acc_lo <= w_acc_lo_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and adder drive
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_mcand_nxt  = r_mcand;
        w_acc_hi_nxt = r_acc_hi;
        w_acc_lo_nxt = r_acc_lo;
        w_cnt_nxt    = r_cnt;
        // Adder inputs held at zero outside RUN so it does not toggle.
        w_add_a      = '0;
        w_add_b      = '0;

        case (r_state)
            StIdle: begin
                if (io_mul.start) begin
                    w_mcand_nxt  = io_mul.a;
                    w_acc_hi_nxt = '0;
                    // Multiplier bits are consumed from acc_lo[0] as the
                    // partial product shifts in from the top.
                    w_acc_lo_nxt = io_mul.b;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = StRun;
                end
            end

            StRun: begin
                w_add_a = r_acc_hi;
                w_add_b = r_acc_lo[0] ? r_mcand : '0;
                // (2N+1)-bit right shift: adder carry-out lands in acc_hi MSB.
                {w_acc_hi_nxt, w_acc_lo_nxt} = {io_mul.add_sum, r_acc_lo[N-1:1]};
                w_cnt_nxt = r_cnt + CntW'(1);
                if (r_cnt == CntLast) begin
                    w_state_nxt = StDone;
                end
            end

            StDone: begin
                w_state_nxt = StIdle;
            end

            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, all decoded from registered state
    // ------------------------------------------------------------------
    assign io_mul.add_a   = w_add_a;
    assign io_mul.add_b   = w_add_b;
    assign io_mul.busy    = (r_state == StRun) || (r_state == StDone);
    assign io_mul.done    = (r_state == StDone);
    assign io_mul.product = {r_acc_hi, r_acc_lo};

endmodule
